// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared matrix-memory constants, read-source encoding and counter helper
package mm_pkg;

    localparam int OB_DEPTH  = 2048;
    localparam int OB_AW     = 11;
    localparam int OB_DW     = 512;
    localparam int OB_RD_LAT = 2;
    localparam int OB_CNT_W  = 16;

    // Owner of a read travelling through the response pipeline
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_ENGINE = 2'd1,
        RD_HOST   = 2'd2
    } rd_src_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [OB_CNT_W-1:0] sat_inc(input logic [OB_CNT_W-1:0] v);
        return (v == {OB_CNT_W{1'b1}}) ? v : v + OB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/out_buf_ram.sv
// rtl/out_buf_ram.sv - simple dual-port storage array, one write port, one registered read port
module out_buf_ram
    import mm_pkg::*;
#(
    parameter int DEPTH = OB_DEPTH,
    parameter int AW    = OB_AW,
    parameter int DW    = OB_DW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port returns the pre-write contents on a same-cycle address match
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/out_buf_responder.sv
// rtl/out_buf_responder.sv - output buffer shared by matrix engine and host, with forwarding and stats
module out_buf_responder
    import mm_pkg::*;
#(
    parameter int DEPTH = OB_DEPTH,
    parameter int AW    = OB_AW,
    parameter int DW    = OB_DW
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_valid,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                rd_addr_valid,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic                rd_data_valid,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [AW-1:0]       host_addr,
    input  logic [DW-1:0]       host_wdata,
    output logic                host_ready,
    output logic [DW-1:0]       host_rdata,
    output logic                host_rdata_valid,
    input  logic                clear_stats,
    output logic [OB_CNT_W-1:0] wr_count,
    output logic [OB_CNT_W-1:0] collision_count
);

    logic          w_host_wr;
    logic          w_host_rd;
    logic          w_ram_we;
    logic          w_ram_re;
    logic [AW-1:0] w_ram_waddr;
    logic [AW-1:0] w_ram_raddr;
    logic [DW-1:0] w_ram_wdata;
    logic [DW-1:0] w_ram_rdata;
    logic          w_fwd_hit;
    logic          w_collision;
    logic [DW-1:0] w_s1_data;
    rd_src_e       w_rd_src;

    rd_src_e       r_s1_src;
    logic          r_s1_fwd;
    logic [DW-1:0] r_s1_fwd_data;

    // The engine always wins its port; the host only gets the port the engine leaves idle
    assign host_ready = host_req & (host_we ? ~wr_valid : ~rd_addr_valid);
    assign w_host_wr  = host_ready & host_we;
    assign w_host_rd  = host_ready & ~host_we;

    assign w_ram_we    = wr_valid | w_host_wr;
    assign w_ram_waddr = wr_valid ? wr_addr : host_addr;
    assign w_ram_wdata = wr_valid ? wr_data : host_wdata;

    assign w_rd_src    = rd_addr_valid ? RD_ENGINE : (w_host_rd ? RD_HOST : RD_NONE);
    assign w_ram_re    = (w_rd_src != RD_NONE);
    assign w_ram_raddr = rd_addr_valid ? rd_addr : host_addr;

    // The array returns old data on a same-cycle hit, so the write data is captured for bypass
    assign w_fwd_hit   = w_ram_we & w_ram_re & (w_ram_waddr == w_ram_raddr);
    assign w_collision = wr_valid & rd_addr_valid & (wr_addr == rd_addr);

    out_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // First stage: remember who owns the read in the array and any same-cycle write to bypass
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_src      <= RD_NONE;
            r_s1_fwd      <= 1'b0;
            r_s1_fwd_data <= '0;
        end else begin
            r_s1_src <= w_rd_src;
            r_s1_fwd <= w_fwd_hit;
            if (w_fwd_hit) begin
                r_s1_fwd_data <= w_ram_wdata;
            end
        end
    end

    assign w_s1_data = r_s1_fwd ? r_s1_fwd_data : w_ram_rdata;

    // Second stage: steer the read result to its requester; data holds between strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data          <= '0;
            rd_data_valid    <= 1'b0;
            host_rdata       <= '0;
            host_rdata_valid <= 1'b0;
        end else begin
            rd_data_valid    <= (r_s1_src == RD_ENGINE);
            host_rdata_valid <= (r_s1_src == RD_HOST);
            if (r_s1_src == RD_ENGINE) begin
                rd_data <= w_s1_data;
            end
            if (r_s1_src == RD_HOST) begin
                host_rdata <= w_s1_data;
            end
        end
    end

    // Saturating statistics; a clear overrides any increment in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_count        <= '0;
            collision_count <= '0;
        end else if (clear_stats) begin
            wr_count        <= '0;
            collision_count <= '0;
        end else begin
            if (wr_valid) begin
                wr_count <= sat_inc(wr_count);
            end
            if (w_collision) begin
                collision_count <= sat_inc(collision_count);
            end
        end
    end

endmodule

// File: tb/tb_out_buf_responder.sv
// tb/tb_out_buf_responder.sv - self-checking bench for out_buf_responder
module tb_out_buf_responder;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int DW    = 512;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_addr_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic [DW-1:0] host_rdata;
    logic          host_rdata_valid;
    logic          clear_stats;
    logic [15:0]   wr_count;
    logic [15:0]   collision_count;

    out_buf_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .wr_valid         (wr_valid),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .rd_addr_valid    (rd_addr_valid),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_ready       (host_ready),
        .host_rdata       (host_rdata),
        .host_rdata_valid (host_rdata_valid),
        .clear_stats      (clear_stats),
        .wr_count         (wr_count),
        .collision_count  (collision_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct {
        logic hreq;
        logic hwe;
        logic wv;
        logic rv;
        logic exp_ready;
    } vec_t;

    // Reference model: plain storage array, response queues keyed by due cycle, integer counters
    logic [DW-1:0] m_mem [DEPTH];
    resp_t         eng_q[$];
    resp_t         host_q[$];
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_hrd;
    int            m_wr;
    int            m_col;
    int            cyc;
    int            n_checks;
    int            n_errors;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) begin
            d[k*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        return {16{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic idle();
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        rd_addr_valid = 1'b0;
        rd_addr       = '0;
        host_req      = 1'b0;
        host_we       = 1'b0;
        host_addr     = '0;
        host_wdata    = '0;
        clear_stats   = 1'b0;
    endtask

    task automatic check_outputs();
        logic ev;
        logic hv;
        ev = (eng_q.size() > 0) && (eng_q[0].due == cyc);
        if (ev) begin
            exp_rd = eng_q[0].data;
            void'(eng_q.pop_front());
        end
        hv = (host_q.size() > 0) && (host_q[0].due == cyc);
        if (hv) begin
            exp_hrd = host_q[0].data;
            void'(host_q.pop_front());
        end
        chk_b("rd_data_valid", rd_data_valid, ev);
        chk_d("rd_data", rd_data, exp_rd);
        chk_b("host_rdata_valid", host_rdata_valid, hv);
        chk_d("host_rdata", host_rdata, exp_hrd);
        chk_w("wr_count", wr_count, 16'((m_wr > 65535) ? 65535 : m_wr));
        chk_w("collision_count", collision_count, 16'((m_col > 65535) ? 65535 : m_col));
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic run_cycle();
        logic  exp_ready;
        resp_t r;
        #1;
        exp_ready = host_req && (host_we ? !wr_valid : !rd_addr_valid);
        chk_b("host_ready", host_ready, exp_ready);
        if (wr_valid) m_mem[wr_addr] = wr_data;
        else if (exp_ready && host_we) m_mem[host_addr] = host_wdata;
        r.due = cyc + 2;
        if (rd_addr_valid) begin
            r.data = m_mem[rd_addr];
            eng_q.push_back(r);
        end else if (exp_ready && !host_we) begin
            r.data = m_mem[host_addr];
            host_q.push_back(r);
        end
        if (clear_stats) begin
            m_wr  = 0;
            m_col = 0;
        end else begin
            if (wr_valid) m_wr++;
            if (wr_valid && rd_addr_valid && wr_addr == rd_addr) m_col++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        #1;
        chk_b("reset_rd_data_valid", rd_data_valid, 1'b0);
        chk_b("reset_host_rdata_valid", host_rdata_valid, 1'b0);
        chk_d("reset_rd_data", rd_data, '0);
        chk_d("reset_host_rdata", host_rdata, '0);
        chk_w("reset_wr_count", wr_count, 16'h0);
        chk_w("reset_collision_count", collision_count, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        eng_q.delete();
        host_q.delete();
        exp_rd  = '0;
        exp_hrd = '0;
        m_wr    = 0;
        m_col   = 0;
    endtask

    vec_t vecs [16];

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_wr     = 0;
        m_col    = 0;
        exp_rd   = '0;
        exp_hrd  = '0;
        idle();
        rstn = 1'b1;
        #2;
        do_reset();

        // Known contents for the small address window used below
        for (int i = 0; i < 16; i++) begin
            idle(); wr_valid = 1'b1; wr_addr = AW'(i); wr_data = rnd_data();
            run_cycle();
        end

        // host_ready arbitration table: {host_req, host_we, wr_valid, rd_addr_valid, expected}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            idle();
            host_req = vecs[i].hreq; host_we = vecs[i].hwe;
            wr_valid = vecs[i].wv;   rd_addr_valid = vecs[i].rv;
            wr_addr = AW'($urandom_range(0, 15)); wr_data = rnd_data();
            rd_addr = AW'($urandom_range(0, 15));
            host_addr = AW'($urandom_range(0, 15)); host_wdata = rnd_data();
            #1;
            chk_b("tbl_host_ready", host_ready, vecs[i].exp_ready);
            run_cycle();
        end
        idle(); run_cycle(); idle(); run_cycle();

        // Write then read one cycle later
        idle(); wr_valid = 1'b1; wr_addr = AW'(5); wr_data = DW'('hA5); run_cycle();
        idle(); rd_addr_valid = 1'b1; rd_addr = AW'(5); run_cycle();
        idle(); run_cycle();
        chk_b("wr_rd_valid", rd_data_valid, 1'b1);
        chk_d("wr_rd_data", rd_data, DW'('hA5));

        // Same-cycle write and read of one address is forwarded and counted as a collision
        idle(); clear_stats = 1'b1; run_cycle();
        idle(); wr_valid = 1'b1; wr_addr = AW'(9); wr_data = DW'('h77);
        rd_addr_valid = 1'b1; rd_addr = AW'(9); run_cycle();
        idle(); run_cycle();
        chk_b("fwd_valid", rd_data_valid, 1'b1);
        chk_d("fwd_data", rd_data, DW'('h77));
        chk_w("fwd_collision", collision_count, 16'd1);

        // Host write blocked by engine write, then accepted next cycle
        idle(); wr_valid = 1'b1; wr_addr = AW'(3); wr_data = DW'('h11); run_cycle();
        idle(); host_req = 1'b1; host_we = 1'b1; host_addr = AW'(3); host_wdata = DW'('h33);
        wr_valid = 1'b1; wr_addr = AW'(100); wr_data = rnd_data();
        rd_addr_valid = 1'b1; rd_addr = AW'(3);
        #1;
        chk_b("host_blocked", host_ready, 1'b0);
        run_cycle();
        idle(); host_req = 1'b1; host_we = 1'b1; host_addr = AW'(3); host_wdata = DW'('h33);
        #1;
        chk_b("host_accepted", host_ready, 1'b1);
        run_cycle();
        chk_d("host_blocked_unchanged", rd_data, DW'('h11));
        idle(); host_req = 1'b1; host_we = 1'b0; host_addr = AW'(3); run_cycle();
        idle(); run_cycle();
        chk_b("host_rd_valid", host_rdata_valid, 1'b1);
        chk_d("host_rd_data", host_rdata, DW'('h33));

        // Back-to-back reads give back-to-back responses in order
        for (int i = 0; i < 8; i++) begin
            idle(); wr_valid = 1'b1; wr_addr = AW'(i); wr_data = pat(i); run_cycle();
        end
        for (int i = 0; i < 9; i++) begin
            idle();
            if (i < 8) begin rd_addr_valid = 1'b1; rd_addr = AW'(i); end
            run_cycle();
            if (i >= 1) begin
                chk_b("b2b_valid", rd_data_valid, 1'b1);
                chk_d("b2b_data", rd_data, pat(i - 1));
            end
        end

        // wr_count saturation and clear priority
        idle(); clear_stats = 1'b1; run_cycle();
        for (int i = 0; i < 65535; i++) begin
            idle(); wr_valid = 1'b1; wr_addr = AW'(16 + (i % (DEPTH - 16)));
            wr_data = {16{32'(i)}};
            run_cycle();
        end
        chk_w("sat_full", wr_count, 16'hFFFF);
        idle(); wr_valid = 1'b1; wr_addr = AW'(200); wr_data = rnd_data(); run_cycle();
        chk_w("sat_hold", wr_count, 16'hFFFF);
        idle(); wr_valid = 1'b1; clear_stats = 1'b1; wr_addr = AW'(201); wr_data = rnd_data();
        run_cycle();
        chk_w("clear_prio", wr_count, 16'h0);

        // Randomized traffic on a small address window to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            idle();
            wr_valid      = ($urandom_range(0, 2) == 0);
            wr_addr       = AW'($urandom_range(0, 15));
            wr_data       = rnd_data();
            rd_addr_valid = 1'($urandom_range(0, 1));
            rd_addr       = AW'($urandom_range(0, 15));
            host_req      = 1'($urandom_range(0, 1));
            host_we       = 1'($urandom_range(0, 1));
            host_addr     = AW'($urandom_range(0, 15));
            host_wdata    = rnd_data();
            clear_stats   = ($urandom_range(0, 63) == 0);
            run_cycle();
        end

        // Reset while a read is in flight drops the response
        idle(); wr_valid = 1'b1; wr_addr = AW'(7); wr_data = pat(77); run_cycle();
        idle(); rd_addr_valid = 1'b1; rd_addr = AW'(7); run_cycle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); run_cycle();
            chk_b("rst_drop", rd_data_valid, 1'b0);
        end
        idle(); rd_addr_valid = 1'b1; rd_addr = AW'(7); run_cycle();
        idle(); run_cycle();
        chk_d("storage_kept", rd_data, pat(77));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/out_buf_responder.md
OUT_BUF_RESPONDER -- requirements
Module: out_buf_responder

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low (clk, rstn).
REQ-002 SHALL provide parameters: DEPTH, default 2048, number of 512-bit words; AW, default 11, address width; DW, default 512, data width.
REQ-003 SHALL provide these ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- wr_valid  in  1  matrix-engine write strobe
- wr_addr  in  AW  matrix-engine write address
- wr_data  in  DW  matrix-engine write data
- rd_addr_valid  in  1  matrix-engine accumulate read request
- rd_addr  in  AW  matrix-engine read address
- rd_data  out  DW  read response data
- rd_data_valid  out  1  read response strobe
- host_req  in  1  host access request
- host_we  in  1  host write (1) or read (0)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_ready  out  1  host request accepted this cycle
- host_rdata  out  DW  host read data
- host_rdata_valid  out  1  host read response strobe
- clear_stats  in  1  synchronous counter clear
- wr_count  out  16  saturating count of accepted engine writes
- collision_count  out  16  saturating count of same-address engine read/write cycles

Function
REQ-004 SHALL accept every engine request unconditionally; the engine port has no backpressure.
REQ-005 SHALL write wr_data to wr_addr in the cycle wr_valid=1.
REQ-006 SHALL return read data for an engine request at cycle T, with rd_data_valid=1, at cycle T+2 exactly.
- Back-to-back requests SHALL give back-to-back responses, in order.
REQ-007 SHALL drive host_ready combinationally from the competing engine strobe:
- host_ready = host_req AND NOT wr_valid when host_we=1.
- host_ready = host_req AND NOT rd_addr_valid when host_we=0.
REQ-008 SHALL perform a host access only in a cycle with host_ready=1.
- Host writes SHALL use the write port.
- Host reads SHALL return host_rdata with host_rdata_valid=1 at T+2.
REQ-009 SHALL make a read issued at cycle T return the newest data of any write accepted at cycles <= T, whether from the engine or the host.
- A same-cycle same-address write SHALL be forwarded.
- A write at T+1 SHALL NOT be visible to that read.
REQ-010 SHALL increment collision_count when wr_valid=1, rd_addr_valid=1 and wr_addr==rd_addr in the same cycle.
REQ-011 SHALL increment wr_count on each engine write; both counters SHALL saturate at 16'hFFFF.
REQ-012 SHALL clear both counters to 0 on clear_stats=1.
- clear_stats SHALL take priority over a simultaneous increment.
REQ-013 SHALL hold rd_data and host_rdata at their last value when the matching valid is 0.
REQ-014 SHALL wrap no addresses; all AW-bit addresses are in range.

Reset
REQ-015 SHALL, on rstn=0, asynchronously force these outputs to 0: rd_data_valid, host_rdata_valid, rd_data, host_rdata, wr_count, collision_count.
REQ-016 SHALL drop reads in flight when reset is asserted mid-operation; no response strobe SHALL appear after rstn rises.
REQ-017 SHALL NOT reset the storage contents.

Structure
REQ-018 SHALL place OB_DEPTH=2048, OB_AW=11, OB_DW=512 and OB_RD_LAT=2 in the shared mm package.
REQ-019 SHALL instantiate one sub-module, out_buf_ram.
- out_buf_ram is a simple dual-port DEPTH x DW memory: 1 write port, 1 read port, registered read data.
- Forwarding and the response valid pipeline SHALL be in out_buf_responder.

Verification
REQ-020 Write 0xA5 to address 5 at T, read address 5 at T+1 -> rd_data=0xA5 with rd_data_valid=1 at T+3.
REQ-021 Same cycle: write 0x77 to address 9 and read address 9 -> rd_data=0x77 two cycles later; collision_count=1.
REQ-022 Host write request to address 3 while wr_valid=1 -> host_ready=0 and storage unchanged; next cycle, wr_valid=0 -> host_ready=1 and write done.
REQ-023 Engine reads of addresses 0..7 on 8 consecutive cycles -> 8 consecutive rd_data_valid pulses with data in order.
REQ-024 wr_count preloaded to 0xFFFF, one more engine write -> stays 0xFFFF; clear_stats plus a write in the same cycle -> 0.
REQ-025 Read issued, rstn pulsed low at T+1 -> no rd_data_valid at T+2; all outputs 0 during reset.
